// File: rtl/mpd_arb_pkg.sv
// Shared types and helpers for the mpd FIFO write arbiter.
package mpd_arb_pkg;

    typedef enum logic {
        IDLE,
        BURST
    } arb_state_e;

    localparam int STATS_W = 16;

    function automatic int id_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin pick: first set request bit strictly after last_ptr, wrapping around.
module rr_pick
    import mpd_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDW     = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     last_ptr,
    output logic               any,
    output logic [IDW-1:0]     pick
);

    logic [IDW-1:0] idx;

    // Scan from the farthest offset down so the nearest requester after last_ptr wins.
    always_comb begin
        any  = |req;
        pick = '0;
        idx  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = IDW'((int'(last_ptr) + k) % NUM_REQ);
            if (req[idx]) begin
                pick = idx;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-atomic round-robin arbiter sharing one FIFO write port between NUM_REQ requesters.
// Define FIFO_WR_ARB_STATS_EN to add per-requester saturating packet counters on PKT_CNT.
module fifo_wr_arbiter
    import mpd_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int WIDTH   = 8,
    localparam int IDW     = id_width(NUM_REQ)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     CLR,
    input  logic [NUM_REQ-1:0]       REQ_VALID,
    input  logic [NUM_REQ-1:0]       REQ_LAST,
    input  logic [NUM_REQ*WIDTH-1:0] REQ_DATA,
    output logic [NUM_REQ-1:0]       REQ_READY,
    input  logic                     FIFO_FULL_N,
    output logic                     FIFO_ENQ,
    output logic [WIDTH-1:0]         FIFO_D_IN,
    output logic                     GRANT_VALID,
`ifdef FIFO_WR_ARB_STATS_EN
    output logic [IDW-1:0]           GRANT_ID,
    output logic [NUM_REQ*STATS_W-1:0] PKT_CNT
`else
    output logic [IDW-1:0]           GRANT_ID
`endif
);

    arb_state_e     state;
    logic [IDW-1:0] owner;
    logic [IDW-1:0] last_ptr;
    logic           any;
    logic [IDW-1:0] pick;
    logic           in_burst;
    logic           xfer;
    logic [WIDTH-1:0] beat [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_beat
        assign beat[i] = REQ_DATA[i*WIDTH +: WIDTH];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req      (REQ_VALID),
        .last_ptr (last_ptr),
        .any      (any),
        .pick     (pick)
    );

    assign in_burst = (state == BURST);
    assign xfer     = in_burst & ~CLR & REQ_VALID[owner] & FIFO_FULL_N;

    // CLR masks the handshake so an aborted beat is neither enqueued nor acknowledged.
    always_comb begin
        REQ_READY = '0;
        if (in_burst && !CLR) begin
            REQ_READY[owner] = FIFO_FULL_N;
        end
        FIFO_ENQ    = xfer;
        FIFO_D_IN   = in_burst ? beat[owner] : '0;
        GRANT_VALID = in_burst;
        GRANT_ID    = in_burst ? owner : '0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            owner    <= '0;
            last_ptr <= IDW'(NUM_REQ - 1);
        end else if (CLR) begin
            state    <= IDLE;
            owner    <= '0;
            last_ptr <= IDW'(NUM_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        owner <= pick;
                        state <= BURST;
                    end
                end
                BURST: begin
                    if (xfer && REQ_LAST[owner]) begin
                        state    <= IDLE;
                        last_ptr <= owner;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    logic [NUM_REQ*STATS_W-1:0] pkt_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pkt_cnt <= '0;
        end else if (CLR) begin
            pkt_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (xfer && REQ_LAST[owner] && owner == IDW'(i) &&
                    pkt_cnt[i*STATS_W +: STATS_W] != {STATS_W{1'b1}}) begin
                    pkt_cnt[i*STATS_W +: STATS_W] <= pkt_cnt[i*STATS_W +: STATS_W] + 16'd1;
                end
            end
        end
    end

    assign PKT_CNT = pkt_cnt;
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin, packet-atomic write arbiter that shares one FIFO write port between NUM_REQ requesters.
- Each requester presents multi-beat packets on a valid/ready/last interface.
- The arbiter grants one requester at a time, forwards that requester's beats to FIFO D_IN/ENQ while FULL_N is high, and releases the grant on the last beat.
- It sits directly in front of the shared FIFO in the mpd datapath.

Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..16.
- WIDTH, 8: data width per beat; must equal the downstream FIFO width.

Ports:
- CLK  in  1  clock; all logic on posedge.
- RST  in  1  asynchronous active-high reset.
- CLR  in  1  synchronous abort; returns the arbiter to IDLE, same values as reset.
- REQ_VALID  in  NUM_REQ  per-requester beat valid.
- REQ_LAST  in  NUM_REQ  per-requester last-beat-of-packet flag; qualified by REQ_VALID.
- REQ_DATA  in  NUM_REQ*WIDTH  packed beats; requester i occupies bits [i*WIDTH +: WIDTH].
- REQ_READY  out  NUM_REQ  per-requester beat accepted.
- FIFO_FULL_N  in  1  FIFO not-full.
- FIFO_ENQ  out  1  FIFO enqueue strobe.
- FIFO_D_IN  out  WIDTH  FIFO write data.
- GRANT_VALID  out  1  a requester currently owns the FIFO.
- GRANT_ID  out  $clog2(NUM_REQ)  index of the owning requester.

Behaviour:
- States: IDLE, BURST (2-state FSM). Registers: state, owner, last_ptr.
- Reset (RST async, or CLR sync):
  - state=IDLE, owner=0, last_ptr=NUM_REQ-1, so requester 0 has highest priority first.
  - All outputs 0: REQ_READY, FIFO_ENQ, FIFO_D_IN, GRANT_VALID, GRANT_ID.
- IDLE:
  - If any REQ_VALID bit is set, owner <= the first set bit scanning from last_ptr+1 upward with wrap-around; state <= BURST.
  - No transfer occurs in IDLE: arbitration costs one bubble cycle per packet.
- BURST:
  - GRANT_VALID=1, GRANT_ID=owner.
  - REQ_READY[owner] = FIFO_FULL_N; all other REQ_READY bits are 0.
  - FIFO_ENQ = REQ_VALID[owner] & FIFO_FULL_N (combinational, zero-latency pass-through).
  - FIFO_D_IN = REQ_DATA[owner] while in BURST; 0 otherwise.
  - A transfer occurs when REQ_VALID[owner] & REQ_READY[owner].
  - A transfer with REQ_LAST[owner]=1 sets state <= IDLE and last_ptr <= owner.
- Atomicity:
  - The grant is held until the last beat, regardless of other requests.
  - Gaps from the owner (valid low) or backpressure (FULL_N low) stall in BURST with FIFO_ENQ=0.
- Single-beat packets (VALID & LAST in the same beat) take 2 cycles: IDLE grant, then BURST transfer.
- Requests from non-owners raised mid-burst are only considered at the next IDLE.
- Fairness:
  - With all requesters continuously valid, the grant order is 0,1,2,...,NUM_REQ-1,0,...
  - No requester waits more than NUM_REQ-1 packets.
- Reset or CLR during BURST aborts the packet immediately:
  - No ENQ in that cycle if CLR is asserted.
  - Remaining beats are the requester's responsibility.
- The arbiter never asserts FIFO_ENQ while FIFO_FULL_N=0.

Optional Feature:
- Macro: FIFO_WR_ARB_STATS_EN.
- When defined:
  - Adds output PKT_CNT [NUM_REQ*16], with one 16-bit counter per requester.
  - A counter increments on each last-beat transfer from that requester and saturates at 16'hFFFF.
  - Counters clear on RST or CLR.
- When undefined: the port and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package mpd_arb_pkg holds:
  - the arb_state_e enum (IDLE, BURST);
  - function id_width(n) returning max(1,$clog2(n));
  - the localparam STATS_W=16.
- Sub-module rr_pick (combinational): inputs req[NUM_REQ] and last_ptr; outputs any and pick. It is a rotate-and-priority-encode with wrap-around, instantiated once.

Test Plan:
- Reset, then idle inputs → all outputs 0; GRANT_VALID=0 for 10 cycles.
- Requester 2 sends 3 beats 8'hA1,A2,A3 (LAST on A3), FULL_N=1 → grant on cycle 1; ENQ high cycles 2-4 with D_IN=A1,A2,A3; back to IDLE on cycle 5.
- All 4 requesters continuously valid with 1-beat packets → GRANT_ID sequence 0,1,2,3,0,1; each ENQ separated by one bubble cycle.
- Requester 1 mid-burst, FULL_N driven low for 3 cycles → ENQ=0 and REQ_READY[1]=0 for those cycles; no beat is lost or duplicated; requester 0 valid throughout never receives ready until requester 1's LAST.
- CLR asserted on beat 2 of a 4-beat packet → no ENQ in the CLR cycle; next cycle is IDLE with last_ptr=NUM_REQ-1, so the following grant goes to the lowest-index valid requester.
- With FIFO_WR_ARB_STATS_EN defined: 5 packets from requester 3 → PKT_CNT[3]=5 and all other counters 0; force a counter to 16'hFFFF, send one more packet → it stays 16'hFFFF.
